ucsbece154b_victim_swap_ctrl: RTL and testbench



---
 rtl/ucsbece154b_victim_swap_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_ucsbece154b_victim_swap_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucsbece154b_victim_swap_ctrl.sv
// L1 miss controller: probes the victim cache, falls back to memory, swaps the evicted line in.
// Optional hit/miss counters are enabled by defining VICTIM_SWAP_STATS_EN.
module ucsbece154b_victim_swap_ctrl #(
    parameter int unsigned ADDR_WIDTH = 56,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [ADDR_WIDTH-1:0] miss_addr_i,
    input  logic                  evict_valid_i,
    input  logic [ADDR_WIDTH-1:0] evict_addr_i,
    input  logic [LINE_WIDTH-1:0] evict_data_i,
    output logic                  fill_valid_o,
    output logic [ADDR_WIDTH-1:0] fill_addr_o,
    output logic [LINE_WIDTH-1:0] fill_data_o,
    output logic                  fill_from_victim_o,
    output logic                  vc_en_o,
    output logic                  vc_flush_o,
    output logic [ADDR_WIDTH-1:0] vc_raddr_o,
    input  logic                  vc_hit_i,
    input  logic [LINE_WIDTH-1:0] vc_rdata_i,
    output logic                  vc_we_o,
    output logic [ADDR_WIDTH-1:0] vc_waddr_o,
    output logic [LINE_WIDTH-1:0] vc_wdata_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    input  logic [LINE_WIDTH-1:0] mem_resp_data_i
`ifdef VICTIM_SWAP_STATS_EN
    ,
    output logic [31:0]           stat_vc_hits_o,
    output logic [31:0]           stat_vc_misses_o
`endif
);

    localparam int unsigned OFFSET_W = $clog2(LINE_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WRITE_VC,
        S_RESP,
        S_DRAIN
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic [ADDR_WIDTH-1:0] evict_addr_q, evict_addr_d;
    logic [LINE_WIDTH-1:0] evict_data_q, evict_data_d;
    logic                  evict_valid_q, evict_valid_d;
    logic                  hit_q, hit_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;

    logic                  miss_ready_d;
    logic                  fill_valid_d;
    logic [ADDR_WIDTH-1:0] fill_addr_d;
    logic [LINE_WIDTH-1:0] fill_data_d;
    logic                  fill_from_victim_d;
    logic [ADDR_WIDTH-1:0] vc_raddr_d;
    logic                  vc_we_d;
    logic [ADDR_WIDTH-1:0] vc_waddr_d;
    logic [LINE_WIDTH-1:0] vc_wdata_d;
    logic                  mem_req_valid_d;
    logic [ADDR_WIDTH-1:0] mem_req_addr_d;

    assign vc_flush_o = flush_i;

    // Next state, captured miss context and next values of the registered outputs
    always_comb begin
        state_d       = state_q;
        miss_addr_d   = miss_addr_q;
        evict_addr_d  = evict_addr_q;
        evict_data_d  = evict_data_q;
        evict_valid_d = evict_valid_q;
        hit_d         = hit_q;
        line_d        = line_q;

        case (state_q)
            S_IDLE: begin
                if (miss_valid_i && miss_ready_o) begin
                    miss_addr_d   = miss_addr_i;
                    evict_valid_d = evict_valid_i;
                    evict_addr_d  = evict_addr_i;
                    evict_data_d  = evict_data_i;
                    state_d       = S_PROBE;
                end
            end
            S_PROBE: begin
                hit_d  = vc_hit_i;
                line_d = vc_rdata_i;
                if (vc_hit_i) begin
                    state_d = evict_valid_q ? S_WRITE_VC : S_RESP;
                end else begin
                    state_d = S_MEM_REQ;
                end
            end
            S_MEM_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (mem_resp_valid_i) begin
                    line_d  = mem_resp_data_i;
                    state_d = evict_valid_q ? S_WRITE_VC : S_RESP;
                end
            end
            S_WRITE_VC: state_d = S_RESP;
            S_RESP:     state_d = S_IDLE;
            S_DRAIN: begin
                if (mem_resp_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            default:    state_d = S_IDLE;
        endcase

        // Flush overrides; an accepted memory request must still have its response drained.
        // IDLE keeps its handshake since miss_ready_o was already presented for this cycle.
        if (flush_i) begin
            case (state_q)
                S_MEM_REQ:                   state_d = mem_req_ready_i ? S_DRAIN : S_IDLE;
                S_MEM_WAIT:                  state_d = mem_resp_valid_i ? S_IDLE : S_DRAIN;
                S_PROBE, S_WRITE_VC, S_RESP: state_d = S_IDLE;
                default: begin
                end
            endcase
        end

        miss_ready_d       = (state_d == S_IDLE);
        mem_req_valid_d    = (state_d == S_MEM_REQ);
        mem_req_addr_d     = '0;
        vc_we_d            = (state_d == S_WRITE_VC);
        vc_waddr_d         = '0;
        vc_wdata_d         = '0;
        fill_valid_d       = (state_d == S_RESP);
        fill_addr_d        = '0;
        fill_data_d        = '0;
        fill_from_victim_d = 1'b0;

        if (mem_req_valid_d) begin
            mem_req_addr_d = {miss_addr_d[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
        end
        if (vc_we_d) begin
            vc_waddr_d = evict_addr_d;
            vc_wdata_d = evict_data_d;
        end
        if (fill_valid_d) begin
            fill_addr_d        = miss_addr_d;
            fill_data_d        = line_d;
            fill_from_victim_d = hit_d;
        end

        // Outside PROBE, point the probe at the evicted line so any LRU touch is harmless
        vc_raddr_d = (state_d == S_PROBE) ? miss_addr_d : evict_addr_d;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q            <= S_IDLE;
            miss_addr_q        <= '0;
            evict_addr_q       <= '0;
            evict_data_q       <= '0;
            evict_valid_q      <= 1'b0;
            hit_q              <= 1'b0;
            line_q             <= '0;
            miss_ready_o       <= 1'b0;
            fill_valid_o       <= 1'b0;
            fill_addr_o        <= '0;
            fill_data_o        <= '0;
            fill_from_victim_o <= 1'b0;
            vc_en_o            <= 1'b0;
            vc_raddr_o         <= '0;
            vc_we_o            <= 1'b0;
            vc_waddr_o         <= '0;
            vc_wdata_o         <= '0;
            mem_req_valid_o    <= 1'b0;
            mem_req_addr_o     <= '0;
        end else begin
            state_q            <= state_d;
            miss_addr_q        <= miss_addr_d;
            evict_addr_q       <= evict_addr_d;
            evict_data_q       <= evict_data_d;
            evict_valid_q      <= evict_valid_d;
            hit_q              <= hit_d;
            line_q             <= line_d;
            miss_ready_o       <= miss_ready_d;
            fill_valid_o       <= fill_valid_d;
            fill_addr_o        <= fill_addr_d;
            fill_data_o        <= fill_data_d;
            fill_from_victim_o <= fill_from_victim_d;
            vc_en_o            <= 1'b1;
            vc_raddr_o         <= vc_raddr_d;
            vc_we_o            <= vc_we_d;
            vc_waddr_o         <= vc_waddr_d;
            vc_wdata_o         <= vc_wdata_d;
            mem_req_valid_o    <= mem_req_valid_d;
            mem_req_addr_o     <= mem_req_addr_d;
        end
    end

`ifdef VICTIM_SWAP_STATS_EN
    // Saturating probe outcome counters; flush leaves them alone
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_vc_hits_o   <= '0;
            stat_vc_misses_o <= '0;
        end else if (state_q == S_PROBE) begin
            if (vc_hit_i) begin
                if (stat_vc_hits_o != 32'hFFFF_FFFF) begin
                    stat_vc_hits_o <= stat_vc_hits_o + 32'd1;
                end
            end else begin
                if (stat_vc_misses_o != 32'hFFFF_FFFF) begin
                    stat_vc_misses_o <= stat_vc_misses_o + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_ucsbece154b_victim_swap_ctrl.sv
// Scoreboard bench for ucsbece154b_victim_swap_ctrl with a small victim-cache and memory model.
module tb_ucsbece154b_victim_swap_ctrl;

    localparam int unsigned AW = 56;
    localparam int unsigned LW = 128;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [LW-1:0] data;
        logic          fv;
        logic [31:0]   cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          miss_valid_i;
    logic          miss_ready_o;
    logic [AW-1:0] miss_addr_i;
    logic          evict_valid_i;
    logic [AW-1:0] evict_addr_i;
    logic [LW-1:0] evict_data_i;
    logic          fill_valid_o;
    logic [AW-1:0] fill_addr_o;
    logic [LW-1:0] fill_data_o;
    logic          fill_from_victim_o;
    logic          vc_en_o;
    logic          vc_flush_o;
    logic [AW-1:0] vc_raddr_o;
    logic          vc_hit_i;
    logic [LW-1:0] vc_rdata_i;
    logic          vc_we_o;
    logic [AW-1:0] vc_waddr_o;
    logic [LW-1:0] vc_wdata_o;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i;
    logic [AW-1:0] mem_req_addr_o;
    logic          mem_resp_valid_i;
    logic [LW-1:0] mem_resp_data_i;
`ifdef VICTIM_SWAP_STATS_EN
    logic [31:0]   stat_vc_hits_o;
    logic [31:0]   stat_vc_misses_o;
`endif

    ucsbece154b_victim_swap_ctrl dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .flush_i            (flush_i),
        .miss_valid_i       (miss_valid_i),
        .miss_ready_o       (miss_ready_o),
        .miss_addr_i        (miss_addr_i),
        .evict_valid_i      (evict_valid_i),
        .evict_addr_i       (evict_addr_i),
        .evict_data_i       (evict_data_i),
        .fill_valid_o       (fill_valid_o),
        .fill_addr_o        (fill_addr_o),
        .fill_data_o        (fill_data_o),
        .fill_from_victim_o (fill_from_victim_o),
        .vc_en_o            (vc_en_o),
        .vc_flush_o         (vc_flush_o),
        .vc_raddr_o         (vc_raddr_o),
        .vc_hit_i           (vc_hit_i),
        .vc_rdata_i         (vc_rdata_i),
        .vc_we_o            (vc_we_o),
        .vc_waddr_o         (vc_waddr_o),
        .vc_wdata_o         (vc_wdata_o),
        .mem_req_valid_o    (mem_req_valid_o),
        .mem_req_ready_i    (mem_req_ready_i),
        .mem_req_addr_o     (mem_req_addr_o),
        .mem_resp_valid_i   (mem_resp_valid_i),
        .mem_resp_data_i    (mem_resp_data_i)
`ifdef VICTIM_SWAP_STATS_EN
        ,
        .stat_vc_hits_o     (stat_vc_hits_o),
        .stat_vc_misses_o   (stat_vc_misses_o)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    exp_t          fill_q [$];
    exp_t          wr_q [$];
    logic [AW-1:0] mem_q [$];

    int            ready_delay = 0;
    int            resp_delay  = 1;
    logic [LW-1:0] mem_data    = '0;
    logic          mem_busy    = 1'b0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Four-entry victim cache model, tags are line addresses
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [LW-1:0] pl_data = '0;
    logic [51:0]   vtag [4];
    logic [LW-1:0] vdata [4];
    logic [3:0]    vval = '0;
    logic [1:0]    vptr = '0;
    logic          wr_en;
    logic [51:0]   wr_tag;
    logic [LW-1:0] wr_data;
    logic [1:0]    wr_idx;
    logic          wr_match;

    always_comb begin
        vc_hit_i   = 1'b0;
        vc_rdata_i = '0;
        for (int i = 0; i < 4; i++) begin
            if (vval[i] && vtag[i] == vc_raddr_o[AW-1:4]) begin
                vc_hit_i   = 1'b1;
                vc_rdata_i = vdata[i];
            end
        end
    end

    always_comb begin
        wr_en    = pl_we || (vc_we_o && vc_en_o);
        wr_tag   = pl_we ? pl_addr[AW-1:4] : vc_waddr_o[AW-1:4];
        wr_data  = pl_we ? pl_data : vc_wdata_o;
        wr_idx   = vptr;
        wr_match = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (vval[i] && vtag[i] == wr_tag) begin
                wr_idx   = 2'(i);
                wr_match = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (wr_en) begin
            vtag[wr_idx]  <= wr_tag;
            vdata[wr_idx] <= wr_data;
            vval[wr_idx]  <= 1'b1;
            if (!wr_match) vptr <= vptr + 2'd1;
        end
    end

    // Memory model: checks the request address, then answers with the configured delays
    initial begin
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_req_valid_o) begin
                mem_busy = 1'b1;
                if (mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_req_unexpected: got addr %h expected no request", mem_req_addr_o);
                end else begin
                    check("mem_req_addr", LW'(mem_req_addr_o), LW'(mem_q.pop_front()));
                end
                repeat (ready_delay) begin @(posedge clk); #1; end
                if (mem_req_valid_o) begin
                    mem_req_ready_i = 1'b1;
                    @(posedge clk); #1;
                    mem_req_ready_i = 1'b0;
                    repeat (resp_delay - 1) begin @(posedge clk); #1; end
                    mem_resp_valid_i = 1'b1;
                    mem_resp_data_i  = mem_data;
                    @(posedge clk); #1;
                    mem_resp_valid_i = 1'b0;
                    mem_resp_data_i  = '0;
                end
                mem_busy = 1'b0;
            end
        end
    end

    // Monitor: every fill strobe and victim write must match the next scoreboard entry
    exp_t fe;
    exp_t we;
    always @(negedge clk) begin
        if (fill_valid_o) begin
            if (fill_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL fill_unexpected: got addr %h expected no fill", fill_addr_o);
            end else begin
                fe = fill_q.pop_front();
                check("fill_addr",  LW'(fill_addr_o), LW'(fe.addr));
                check("fill_data",  fill_data_o, fe.data);
                check("fill_from_victim", LW'(fill_from_victim_o), LW'(fe.fv));
                check("fill_cycle", LW'(cyc), LW'(fe.cyc));
            end
        end
        if (vc_we_o) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL vc_we_unexpected: got addr %h expected no write", vc_waddr_o);
            end else begin
                we = wr_q.pop_front();
                check("vc_waddr",    LW'(vc_waddr_o), LW'(we.addr));
                check("vc_wdata",    vc_wdata_o, we.data);
                check("vc_we_cycle", LW'(cyc), LW'(we.cyc));
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_miss_ready"},   LW'(miss_ready_o), '0);
        check({tag, "_vc_en"},        LW'(vc_en_o), '0);
        check({tag, "_fill_valid"},   LW'(fill_valid_o), '0);
        check({tag, "_fill_addr"},    LW'(fill_addr_o), '0);
        check({tag, "_fill_data"},    fill_data_o, '0);
        check({tag, "_fill_victim"},  LW'(fill_from_victim_o), '0);
        check({tag, "_vc_raddr"},     LW'(vc_raddr_o), '0);
        check({tag, "_vc_we"},        LW'(vc_we_o), '0);
        check({tag, "_vc_waddr"},     LW'(vc_waddr_o), '0);
        check({tag, "_vc_wdata"},     vc_wdata_o, '0);
        check({tag, "_mem_req_valid"}, LW'(mem_req_valid_o), '0);
        check({tag, "_mem_req_addr"}, LW'(mem_req_addr_o), '0);
    endtask

    // Presents a miss for exactly one cycle starting at the current drive point
    task automatic issue_miss(input logic [AW-1:0] a, input logic ev, input logic [AW-1:0] ea,
                              input logic [LW-1:0] ed, output logic [31:0] c0);
        check("miss_ready_at_issue", LW'(miss_ready_o), LW'(1));
        miss_valid_i  = 1'b1;
        miss_addr_i   = a;
        evict_valid_i = ev;
        evict_addr_i  = ea;
        evict_data_i  = ed;
        c0            = cyc;
        @(posedge clk); #1;
        miss_valid_i  = 1'b0;
        evict_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!miss_ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle", LW'(miss_ready_o), LW'(1));
    endtask

    task automatic wait_mem_idle();
        int n = 0;
        while (mem_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_mem_idle", LW'(mem_busy), '0);
    endtask

    localparam logic [LW-1:0] D_DEAD = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
    localparam logic [LW-1:0] D_BEEF = 128'hBEEF_BEEF_BEEF_BEEF_BEEF_BEEF_BEEF_BEEF;
    localparam logic [LW-1:0] D_2222 = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
    localparam logic [LW-1:0] D_5555 = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    localparam logic [LW-1:0] D_7777 = 128'h7777_7777_7777_7777_7777_7777_7777_7777;
    localparam logic [LW-1:0] D_9999 = 128'h9999_9999_9999_9999_9999_9999_9999_9999;
    localparam logic [LW-1:0] D_AAAA = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] c0;
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        miss_valid_i  = 1'b0;
        miss_addr_i   = '0;
        evict_valid_i = 1'b0;
        evict_addr_i  = '0;
        evict_data_i  = '0;

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        pl_we = 1'b1; pl_addr = 56'h1000; pl_data = D_DEAD;
        @(posedge clk); #1;
        pl_we  = 1'b0;
        rst_ni = 1'b1;
        @(posedge clk); #1;
        check("post_reset_miss_ready", LW'(miss_ready_o), LW'(1));
        check("post_reset_vc_en", LW'(vc_en_o), LW'(1));

        // Victim hit, no evict
        issue_miss(56'h1004, 1'b0, '0, '0, c0);
        fill_q.push_back('{addr: 56'h1004, data: D_DEAD, fv: 1'b1, cyc: c0 + 32'd2});
        wait_idle();

        // Victim miss with evict, issued back-to-back in the IDLE cycle
        ready_delay = 2; resp_delay = 3; mem_data = D_BEEF;
        mem_q.push_back(56'h5000);
        issue_miss(56'h5008, 1'b1, 56'h2000, D_2222, c0);
        wr_q.push_back('{addr: 56'h2000, data: D_2222, fv: 1'b0, cyc: c0 + 32'd8});
        fill_q.push_back('{addr: 56'h5008, data: D_BEEF, fv: 1'b0, cyc: c0 + 32'd9});
        wait_idle();

        // Victim hit with evict, then the evicted line is probed
        issue_miss(56'h1008, 1'b1, 56'h2000, D_5555, c0);
        wr_q.push_back('{addr: 56'h2000, data: D_5555, fv: 1'b0, cyc: c0 + 32'd2});
        fill_q.push_back('{addr: 56'h1008, data: D_DEAD, fv: 1'b1, cyc: c0 + 32'd3});
        wait_idle();
        issue_miss(56'h200C, 1'b0, '0, '0, c0);
        fill_q.push_back('{addr: 56'h200C, data: D_5555, fv: 1'b1, cyc: c0 + 32'd2});
        wait_idle();

        // Flush in MEM_WAIT: drain the response, no fill and no victim write
        ready_delay = 0; resp_delay = 5; mem_data = D_9999;
        mem_q.push_back(56'h6000);
        issue_miss(56'h6000, 1'b1, 56'h7000, D_7777, c0);
        repeat (3) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(negedge clk);
        check("vc_flush", LW'(vc_flush_o), LW'(1));
        @(posedge clk); #1;
        flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("drain_miss_ready", LW'(miss_ready_o), '0);
            @(posedge clk); #1;
        end
        check("after_drain_miss_ready", LW'(miss_ready_o), LW'(1));
        wait_mem_idle();

`ifdef VICTIM_SWAP_STATS_EN
        check("stat_hits", LW'(stat_vc_hits_o), LW'(3));
        check("stat_misses", LW'(stat_vc_misses_o), LW'(2));
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(posedge clk); #1;
        check("stat_hits_after_flush", LW'(stat_vc_hits_o), LW'(3));
        check("stat_misses_after_flush", LW'(stat_vc_misses_o), LW'(2));
`endif

        // Reset asserted while the memory request is still pending
        ready_delay = 6; resp_delay = 1;
        mem_q.push_back(56'h8030);
        issue_miss(56'h803C, 1'b0, '0, '0, c0);
        @(posedge clk); #1;
        check("pre_reset_mem_req_valid", LW'(mem_req_valid_o), LW'(1));
        check("pre_reset_mem_req_addr", LW'(mem_req_addr_o), LW'(56'h8030));
        @(posedge clk); #1;
        rst_ni = 1'b0;
        @(posedge clk); #1;
        check_zero("mid_reset");
        rst_ni = 1'b1;
        @(posedge clk); #1;
        check("release_miss_ready", LW'(miss_ready_o), LW'(1));
        check("release_vc_en", LW'(vc_en_o), LW'(1));
`ifdef VICTIM_SWAP_STATS_EN
        check("stat_hits_reset", LW'(stat_vc_hits_o), '0);
        check("stat_misses_reset", LW'(stat_vc_misses_o), '0);
`endif
        wait_mem_idle();

        // Normal operation after reset: one victim hit, one victim miss
        issue_miss(56'h1000, 1'b0, '0, '0, c0);
        fill_q.push_back('{addr: 56'h1000, data: D_DEAD, fv: 1'b1, cyc: c0 + 32'd2});
        wait_idle();
        ready_delay = 0; resp_delay = 1; mem_data = D_AAAA;
        mem_q.push_back(56'h9000);
        issue_miss(56'h9004, 1'b0, '0, '0, c0);
        fill_q.push_back('{addr: 56'h9004, data: D_AAAA, fv: 1'b0, cyc: c0 + 32'd4});
        wait_idle();

        repeat (5) @(posedge clk);
        #1;
        check("fill_q_drained", LW'(fill_q.size()), '0);
        check("wr_q_drained", LW'(wr_q.size()), '0);
        check("mem_q_drained", LW'(mem_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
